// File: rtl/pin_attempt_ctrl.sv
// pin_attempt_ctrl
//
// Attempt/lockout sequencer placed between the board inputs and the PIN
// checker. It forwards the user's submit strobe only while idle, reacts to
// rising edges of the checker's correct/incorrect flags, counts consecutive
// failures and, with lockout built in, blocks entry for LOCK_CYCLES cycles
// after MAX_TRIES failures before pulsing a checker reset.
//
// Build option: define PIN_LOCKOUT_EN to build the lockout path (LOCKED and
// RELEASE states plus the lock timer). Without it, locked and chk_reset are
// tied low and a failure always returns to IDLE.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-high reset
//   submit_in     in   user submit strobe
//   chk_correct   in   checker "correct" level flag
//   chk_incorrect in   checker "incorrect" level flag
//   submit_out    out  submit_in gated by IDLE (combinational)
//   chk_reset     out  one-cycle checker reset after a lockout
//   granted       out  one-cycle pulse when a PIN is accepted
//   locked        out  high for the whole lockout
//   fail_count    out  consecutive failures, saturating at MAX_TRIES
//   err           out  sticky; both flags rose together while idle
//   state_dbg     out  current FSM state encoding, for checkers/debug
//
// Handshake: there is no valid/ready pair here. submit_in is a plain strobe
// that passes only in IDLE; checker results are single rising edges and any
// edge that arrives outside IDLE is dropped (the checker holds its result
// long enough that this cannot lose a real result).

module pin_attempt_ctrl #(
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 1024,
  parameter int CNT_W       = 2,
  parameter int TMR_W       = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             submit_in,
  input  logic             chk_correct,
  input  logic             chk_incorrect,
  output logic             submit_out,
  output logic             chk_reset,
  output logic             granted,
  output logic             locked,
  output logic [CNT_W-1:0] fail_count,
  output logic             err,
  output logic [2:0]       state_dbg
);

  // Reject parameter sets whose counters cannot hold their limits.
  if (MAX_TRIES < 1 || MAX_TRIES >= (1 << CNT_W)) begin : g_bad_cnt
    $error("pin_attempt_ctrl: CNT_W cannot hold MAX_TRIES");
  end
  if (LOCK_CYCLES < 1 || (LOCK_CYCLES - 1) >= (1 << TMR_W)) begin : g_bad_tmr
    $error("pin_attempt_ctrl: TMR_W cannot hold LOCK_CYCLES-1");
  end

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TRIES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT   = 3'd1,
    FAIL    = 3'd2,
    LOCKED  = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] fail_next;
  logic             err_next;
  logic             correct_q, incorrect_q;
  logic             correct_rise, incorrect_rise;

  // Previous-cycle copies of the flags; they keep tracking in every state so
  // a level that was already high when we return to IDLE is not a new rise.
  assign correct_rise   = chk_correct   & ~correct_q;
  assign incorrect_rise = chk_incorrect & ~incorrect_q;

`ifdef PIN_LOCKOUT_EN
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(LOCK_CYCLES - 1);
  logic [TMR_W-1:0] tmr, tmr_next;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      fail_count  <= '0;
      err         <= 1'b0;
      correct_q   <= 1'b0;
      incorrect_q <= 1'b0;
`ifdef PIN_LOCKOUT_EN
      tmr         <= '0;
`endif
    end else begin
      state       <= state_next;
      fail_count  <= fail_next;
      err         <= err_next;
      correct_q   <= chk_correct;
      incorrect_q <= chk_incorrect;
`ifdef PIN_LOCKOUT_EN
      tmr         <= tmr_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    fail_next  = fail_count;
    err_next   = err;
`ifdef PIN_LOCKOUT_EN
    tmr_next   = tmr;
`endif
    case (state)
      IDLE: begin
        // A simultaneous rise of both flags is treated as a failure.
        if (incorrect_rise) begin
          state_next = FAIL;
          if (correct_rise) err_next = 1'b1;
        end else if (correct_rise) begin
          state_next = GRANT;
        end
      end
      GRANT: begin
        fail_next  = '0;
        state_next = IDLE;
      end
      FAIL: begin
        fail_next  = (fail_count == MAX_CNT) ? MAX_CNT : fail_count + 1'b1;
        state_next = IDLE;
`ifdef PIN_LOCKOUT_EN
        if (fail_next == MAX_CNT) begin
          state_next = LOCKED;
          tmr_next   = TMR_LOAD;
        end
`endif
      end
`ifdef PIN_LOCKOUT_EN
      LOCKED: begin
        // Timer runs LOCK_CYCLES-1 down to 0, so LOCKED lasts LOCK_CYCLES.
        if (tmr == '0) state_next = RELEASE;
        else           tmr_next   = tmr - 1'b1;
      end
      RELEASE: begin
        fail_next  = '0;
        state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  assign submit_out = submit_in & (state == IDLE);
  assign granted    = (state == GRANT);
  assign state_dbg  = state;

`ifdef PIN_LOCKOUT_EN
  assign locked    = (state == LOCKED);
  assign chk_reset = (state == RELEASE);
`else
  assign locked    = 1'b0;
  assign chk_reset = 1'b0;
`endif

endmodule

// File: tb/tb_pin_attempt_ctrl.sv
// Directed testbench for pin_attempt_ctrl with MAX_TRIES=3, LOCK_CYCLES=8.
// Lockout scenarios run when PIN_LOCKOUT_EN is defined; otherwise the
// saturation-without-lockout scenario runs.

module tb_pin_attempt_ctrl;

  localparam int MAX_TRIES   = 3;
  localparam int LOCK_CYCLES = 8;
  localparam int CNT_W       = 2;
  localparam int TMR_W       = 3;

  logic             clk;
  logic             reset;
  logic             submit_in;
  logic             chk_correct;
  logic             chk_incorrect;
  logic             submit_out;
  logic             chk_reset;
  logic             granted;
  logic             locked;
  logic [CNT_W-1:0] fail_count;
  logic             err;
  logic [2:0]       state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;

  pin_attempt_ctrl #(
    .MAX_TRIES  (MAX_TRIES),
    .LOCK_CYCLES(LOCK_CYCLES),
    .CNT_W      (CNT_W),
    .TMR_W      (TMR_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .submit_in    (submit_in),
    .chk_correct  (chk_correct),
    .chk_incorrect(chk_incorrect),
    .submit_out   (submit_out),
    .chk_reset    (chk_reset),
    .granted      (granted),
    .locked       (locked),
    .fail_count   (fail_count),
    .err          (err),
    .state_dbg    (state_dbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one flag rise, check the reaction, then drop the flags.
  task automatic rise_pair(input logic c, input logic i, input logic exp_g,
                           input int exp_cnt, input string tag);
    chk_correct   = c;
    chk_incorrect = i;
    step();
    check({tag, "_grant"}, granted, exp_g);
    step();
    check({tag, "_cnt"}, fail_count, exp_cnt);
    check({tag, "_locked"}, locked, 0);
    chk_correct   = 0;
    chk_incorrect = 0;
    step();
    check({tag, "_grant_off"}, granted, 0);
  endtask

  task automatic do_reset();
    reset = 1;
    #1;
    check("rst_err", err, 0);
    check("rst_cnt", fail_count, 0);
    check("rst_locked", locked, 0);
    step();
    reset = 0;
    step();
  endtask

  initial begin
    int n;
    reset = 1; submit_in = 0; chk_correct = 0; chk_incorrect = 0;
    #3;
    check("rst_granted", granted, 0);
    check("rst_locked0", locked, 0);
    check("rst_chk_reset", chk_reset, 0);
    check("rst_err0", err, 0);
    check("rst_cnt0", fail_count, 0);
    submit_in = 1; #1;
    check("rst_submit_hi", submit_out, 1);
    submit_in = 0; #1;
    check("rst_submit_lo", submit_out, 0);
    step(); step();
    reset = 0;
    step();

    // Single correct rise: one-cycle grant.
    chk_correct = 1;
    step();
    check("t1_grant", granted, 1);
    check("t1_locked", locked, 0);
    step();
    check("t1_grant_once", granted, 0);
    check("t1_cnt", fail_count, 0);
    chk_correct = 0;
    step();

    // Two failures then success.
    rise_pair(0, 1, 0, 1, "t2_f1");
    rise_pair(0, 1, 0, 2, "t2_f2");
    rise_pair(1, 0, 1, 0, "t2_ok");

    // Both flags rising together counts as a failure and sets err.
    check("t4_err_pre", err, 0);
    rise_pair(1, 1, 0, 1, "t4_both");
    check("t4_err", err, 1);
    step(); step(); step();
    check("t4_err_sticky", err, 1);
    do_reset();

`ifdef PIN_LOCKOUT_EN
    // Three failures: lockout of exactly LOCK_CYCLES, then chk_reset.
    rise_pair(0, 1, 0, 1, "t3_f1");
    rise_pair(0, 1, 0, 2, "t3_f2");
    chk_incorrect = 1;
    step();
    check("t3_fail_nolock", locked, 0);
    step();
    chk_incorrect = 0;
    check("t3_cnt3", fail_count, 3);
    n = 0;
    while (locked && n < 20) begin
      n++;
      submit_in = 1;
      #1;
      check("t3_submit_gated", submit_out, 0);
      check("t3_no_grant", granted, 0);
      check("t3_no_chk_reset", chk_reset, 0);
      submit_in = 0;
      if (n == 3) chk_correct = 1;  // ignored while locked
      step();
    end
    check("t3_lock_len", n, LOCK_CYCLES);
    check("t3_chk_reset", chk_reset, 1);
    check("t3_unlocked", locked, 0);
    step();
    check("t3_chk_reset_once", chk_reset, 0);
    check("t3_cnt_clr", fail_count, 0);
    check("t3_held_no_grant", granted, 0);
    chk_correct = 0;
    submit_in = 1; #1;
    check("t3_submit_open", submit_out, 1);
    submit_in = 0;
    step();

    // Reset during lockout cycle 4.
    rise_pair(0, 1, 0, 1, "t5_f1");
    rise_pair(0, 1, 0, 2, "t5_f2");
    chk_incorrect = 1;
    step(); step();
    chk_incorrect = 0;
    check("t5_locked_c1", locked, 1);
    step(); step(); step();
    check("t5_locked_c4", locked, 1);
    reset = 1;
    #1;
    check("t5_async_unlock", locked, 0);
    check("t5_cnt_clr", fail_count, 0);
    check("t5_no_chk_reset", chk_reset, 0);
    step();
    reset = 0;
    for (int k = 0; k < 12; k++) begin
      check("t5_quiet_chk_reset", chk_reset, 0);
      check("t5_quiet_locked", locked, 0);
      step();
    end
    submit_in = 1; #1;
    check("t5_submit", submit_out, 1);
    submit_in = 0;
`else
    // No lockout: fail_count saturates, never locks.
    for (int k = 1; k <= 5; k++) begin
      chk_incorrect = 1;
      step();
      check("t6_locked", locked, 0);
      check("t6_chk_reset", chk_reset, 0);
      step();
      check("t6_cnt", fail_count, (k > MAX_TRIES) ? MAX_TRIES : k);
      check("t6_locked2", locked, 0);
      chk_incorrect = 0;
      step();
      submit_in = 1; #1;
      check("t6_submit_hi", submit_out, 1);
      submit_in = 0; #1;
      check("t6_submit_lo", submit_out, 0);
    end
`endif

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
